controle_busca: RTL and testbench
=================================

CONTROLE_BUSCA -- requirements
Module: controle_busca

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, meaning the number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter PC_RESET, default 32'd0, meaning the byte address of the first fetch.
REQ-003 SHALL have port clock  in  1  meaning the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port stall  in  1  meaning a hazard hold: freeze the PC and the IF/ID register.
REQ-006 SHALL have port desvio  in  1  meaning a resolved taken branch (redirect).
REQ-007 SHALL have port alvo_desvio  in  32  meaning the branch target byte address.
REQ-008 SHALL have port instrucao_mem  in  32  meaning the word returned combinationally by the instruction memory for endereco.
REQ-009 SHALL have port endereco  out  32  meaning the fetch byte address to the memory; the memory indexes word endereco/4.
REQ-010 SHALL have port if_id_instrucao  out  32  meaning the IF/ID instruction register.
REQ-011 SHALL have port if_id_pc4  out  32  meaning the IF/ID PC+4 register.
REQ-012 SHALL have port if_id_valido  out  1  meaning the IF/ID contents are a real instruction, not a bubble.
REQ-013 SHALL have port fim  out  1  meaning the PC is beyond the end of memory and fetch is halted.
REQ-014 SHALL have port erro_alinhamento  out  1  meaning a sticky flag set by a misaligned branch target.
REQ-015 SHALL have port estado  out  2  meaning the FSM state: INICIO=0, BUSCA=1, PARADO=2, FIM=3.
REQ-016 SHALL have port num_buscas  out  16  meaning a count of valid instructions loaded into IF/ID; it saturates at 16'hFFFF.

Function
REQ-017 SHALL drive endereco directly from the registered PC; there is no combinational path from any input to endereco.
REQ-018 SHALL apply the per-edge priority reset > desvio > stall > normal fetch.
REQ-019 INICIO SHALL last exactly one cycle with no capture, the PC held and if_id_valido=0, then go to BUSCA; if stall=1 it SHALL remain in INICIO; if desvio=1 it SHALL load the PC from the target and go to BUSCA.
REQ-020 BUSCA, when PC < 4*MEM_WORDS and stall=0 and desvio=0, SHALL on each edge do all of the following: load if_id_instrucao from instrucao_mem; load if_id_pc4 with PC+4; set if_id_valido=1; set PC to PC+4; increment num_buscas.
REQ-021 The instruction at address A SHALL appear in IF/ID on the edge that ends the cycle in which endereco=A, so fetch latency is one cycle.
REQ-022 When stall=1 and desvio=0 in BUSCA, the FSM SHALL go to PARADO, and the PC, IF/ID and num_buscas SHALL all hold.
REQ-023 PARADO SHALL persist while stall=1 and return to BUSCA on the edge where stall=0, with no extra bubble; the next edge in BUSCA resumes fetch at the held PC.
REQ-024 On desvio=1 in BUSCA or PARADO, including when stall=1, the PC SHALL be set to {alvo_desvio[31:2],2'b00}, IF/ID SHALL be flushed (if_id_instrucao=0, if_id_pc4=0, if_id_valido=0), and the FSM SHALL go to BUSCA.
REQ-025 If a redirect target is at or beyond 4*MEM_WORDS, the FSM SHALL go to FIM instead of BUSCA.
REQ-026 If alvo_desvio[1:0]!=0 on any accepted redirect, erro_alinhamento SHALL be set to 1 and held until reset; the redirect itself proceeds with the aligned address.
REQ-027 In BUSCA, if PC >= 4*MEM_WORDS, the FSM SHALL go to FIM with no capture, if_id_valido=0 and the PC held.
REQ-028 fim SHALL equal 1 exactly when estado=FIM.
REQ-029 In FIM, stall SHALL be ignored, and only desvio or reset SHALL leave the state.
REQ-030 PC arithmetic SHALL be 32-bit modulo 2^32; a PC that wraps to 0 without reaching FIM is acceptable only when MEM_WORDS=2^30.
REQ-031 num_buscas SHALL NOT count bubbles, flushes or held cycles.

Reset
REQ-032 While reset=1 at an edge, all registers SHALL take their reset values: PC=PC_RESET, estado=INICIO, if_id_instrucao=0, if_id_pc4=0, if_id_valido=0, erro_alinhamento=0, num_buscas=0.
REQ-033 Reset SHALL override a simultaneous desvio or stall and SHALL abort any state, including mid-PARADO and FIM.
REQ-034 The first valid IF/ID SHALL appear on the second edge after reset deasserts.

Verification
REQ-035 Sequential fetch: release reset with memory word k = 32'h100+k -> endereco steps 0,0,4,8,...; if_id_instrucao=32'h100, 32'h101, ...; if_id_pc4=4, 8, ...; num_buscas increments by 1 per edge.
REQ-036 Stall: assert stall for 3 cycles with PC=12 -> estado=2 for 3 cycles; endereco stays 12; IF/ID is unchanged; on release the next capture is word 3 with no bubble.
REQ-037 Branch: desvio=1, alvo_desvio=80 while PC=76 -> next endereco=80, if_id_valido=0 for one edge, then word 20 captured; word 19 is never valid in IF/ID.
REQ-038 End of memory: run from PC=120 with MEM_WORDS=32 -> words 30 and 31 captured, then fim=1, endereco=128 held, if_id_valido=0; desvio to 20 -> estado=BUSCA, word 5 captured.
REQ-039 Misaligned and simultaneous events: desvio=1 with alvo_desvio=82 and stall=1 -> PC=80, erro_alinhamento=1 and sticky; reset asserted in PARADO -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/controle_busca.sv
// Instruction fetch control: PC register, IF/ID pipeline register and a small FSM
// that sequences start-up, hazard holds, branch redirects and end-of-memory halting.
module controle_busca #(
  parameter int unsigned MEM_WORDS = 32,
  parameter logic [31:0] PC_RESET  = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        desvio,
  input  logic [31:0] alvo_desvio,
  input  logic [31:0] instrucao_mem,
  output logic [31:0] endereco,
  output logic [31:0] if_id_instrucao,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valido,
  output logic        fim,
  output logic        erro_alinhamento,
  output logic [1:0]  estado,
  output logic [15:0] num_buscas
);

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2,
    FIM    = 2'd3
  } estado_t;

  // 33-bit limit so that MEM_WORDS = 2^30 (a full 4 GiB space) does not overflow.
  localparam logic [32:0] LIMITE = 33'(MEM_WORDS) * 33'd4;

  estado_t     r_estado, w_estadoNext;
  logic [31:0] r_pc, w_pcNext;
  logic [31:0] r_instrucao, w_instrucaoNext;
  logic [31:0] r_pc4, w_pc4Next;
  logic        r_valido, w_validoNext;
  logic        r_erro, w_erroNext;
  logic [15:0] r_buscas, w_buscasNext;

  logic [31:0] w_alvoAlinhado;
  logic        w_alvoFora;
  logic        w_pcDentro;
  logic [31:0] w_pcMais4;

  assign w_alvoAlinhado = {alvo_desvio[31:2], 2'b00};
  assign w_alvoFora     = {1'b0, w_alvoAlinhado} >= LIMITE;
  assign w_pcDentro     = {1'b0, r_pc} < LIMITE;
  assign w_pcMais4      = r_pc + 32'd4;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= INICIO;
      r_pc        <= PC_RESET;
      r_instrucao <= 32'd0;
      r_pc4       <= 32'd0;
      r_valido    <= 1'b0;
      r_erro      <= 1'b0;
      r_buscas    <= 16'd0;
    end else begin
      r_estado    <= w_estadoNext;
      r_pc        <= w_pcNext;
      r_instrucao <= w_instrucaoNext;
      r_pc4       <= w_pc4Next;
      r_valido    <= w_validoNext;
      r_erro      <= w_erroNext;
      r_buscas    <= w_buscasNext;
    end
  end

  // A redirect wins over stall in every state; otherwise each state decides on its own.
  always_comb begin
    w_estadoNext    = r_estado;
    w_pcNext        = r_pc;
    w_instrucaoNext = r_instrucao;
    w_pc4Next       = r_pc4;
    w_validoNext    = r_valido;
    w_erroNext      = r_erro;
    w_buscasNext    = r_buscas;

    if (desvio) begin
      w_pcNext        = w_alvoAlinhado;
      w_instrucaoNext = 32'd0;
      w_pc4Next       = 32'd0;
      w_validoNext    = 1'b0;
      w_erroNext      = r_erro | (alvo_desvio[1:0] != 2'b00);
      w_estadoNext    = w_alvoFora ? FIM : BUSCA;
    end else begin
      case (r_estado)
        INICIO: begin
          if (!stall) w_estadoNext = BUSCA;
        end
        BUSCA: begin
          if (stall) begin
            w_estadoNext = PARADO;
          end else if (w_pcDentro) begin
            w_instrucaoNext = instrucao_mem;
            w_pc4Next       = w_pcMais4;
            w_validoNext    = 1'b1;
            w_pcNext        = w_pcMais4;
            if (r_buscas != 16'hFFFF) w_buscasNext = r_buscas + 16'd1;
          end else begin
            w_estadoNext = FIM;
            w_validoNext = 1'b0;
          end
        end
        PARADO: begin
          if (!stall) w_estadoNext = BUSCA;
        end
        FIM: begin
          w_estadoNext = FIM;
        end
        default: begin
          w_estadoNext = INICIO;
        end
      endcase
    end
  end

  assign endereco         = r_pc;
  assign if_id_instrucao  = r_instrucao;
  assign if_id_pc4        = r_pc4;
  assign if_id_valido     = r_valido;
  assign fim              = (r_estado == FIM);
  assign erro_alinhamento = r_erro;
  assign estado           = r_estado;
  assign num_buscas       = r_buscas;

endmodule

// File: tb/tb_controle_busca.sv
// Self-checking bench for controle_busca: directed fetch/stall/branch/end-of-memory
// scenarios followed by random traffic, all compared against a behavioural model.
module tb_controle_busca;

  localparam int unsigned MEM_WORDS = 32;
  localparam logic [63:0] LIMIT     = 64'(MEM_WORDS) * 64'd4;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        desvio;
  logic [31:0] alvo_desvio;
  logic [31:0] instrucao_mem;
  logic [31:0] endereco;
  logic [31:0] if_id_instrucao;
  logic [31:0] if_id_pc4;
  logic        if_id_valido;
  logic        fim;
  logic        erro_alinhamento;
  logic [1:0]  estado;
  logic [15:0] num_buscas;

  logic [31:0] mem [MEM_WORDS];

  int checks   = 0;
  int failures = 0;

  // Reference model: expected architectural values after each edge.
  logic [31:0] mPc;
  int          mMode;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  logic        mValid;
  logic        mErr;
  int          mCount;

  controle_busca #(
    .MEM_WORDS(MEM_WORDS),
    .PC_RESET (32'd0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .desvio          (desvio),
    .alvo_desvio     (alvo_desvio),
    .instrucao_mem   (instrucao_mem),
    .endereco        (endereco),
    .if_id_instrucao (if_id_instrucao),
    .if_id_pc4       (if_id_pc4),
    .if_id_valido    (if_id_valido),
    .fim             (fim),
    .erro_alinhamento(erro_alinhamento),
    .estado          (estado),
    .num_buscas      (num_buscas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (64'(addr) < LIMIT) return mem[addr[31:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign instrucao_mem = memWord(endereco);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Spec rules in priority order: reset, redirect, stall/hold, fetch or halt.
  task automatic modelEdge(input logic rst, input logic st, input logic dv,
                           input logic [31:0] alvo);
    logic [31:0] target;
    if (rst) begin
      mPc = 32'd0; mMode = 0; mInstr = 0; mPc4 = 0; mValid = 0; mErr = 0; mCount = 0;
    end else if (dv) begin
      target = alvo & 32'hFFFF_FFFC;
      mPc = target; mInstr = 0; mPc4 = 0; mValid = 0;
      if (alvo % 4 != 0) mErr = 1'b1;
      mMode = (64'(target) >= LIMIT) ? 3 : 1;
    end else if (mMode == 0) begin
      if (!st) mMode = 1;
    end else if (mMode == 1) begin
      if (st) mMode = 2;
      else if (64'(mPc) < LIMIT) begin
        mInstr = mem[mPc / 4];
        mPc4   = mPc + 4;
        mValid = 1'b1;
        mPc    = mPc + 4;
        mCount = (mCount < 65535) ? mCount + 1 : 65535;
      end else begin
        mMode = 3; mValid = 1'b0;
      end
    end else if (mMode == 2) begin
      if (!st) mMode = 1;
    end
  endtask

  task automatic compareAll();
    checkOutput("endereco",  endereco,        mPc);
    checkOutput("instrucao", if_id_instrucao, mInstr);
    checkOutput("pc4",       if_id_pc4,       mPc4);
    checkOutput("valido",    32'(if_id_valido),     32'(mValid));
    checkOutput("fim",       32'(fim),              32'(mMode == 3));
    checkOutput("erro",      32'(erro_alinhamento), 32'(mErr));
    checkOutput("estado",    32'(estado),           32'(mMode));
    checkOutput("buscas",    32'(num_buscas),       32'(mCount));
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic dv,
                               input logic [31:0] alvo);
    reset = rst; stall = st; desvio = dv; alvo_desvio = alvo;
    modelEdge(rst, st, dv, alvo);
    @(posedge clock);
    #1;
    compareAll();
  endtask

  task automatic runNormal(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'h100 + k;
    reset = 1'b1; stall = 1'b0; desvio = 1'b0; alvo_desvio = 32'd0;
    mPc = 0; mMode = 0; mInstr = 0; mPc4 = 0; mValid = 0; mErr = 0; mCount = 0;

    // Reset, including a reset that overrides desvio and stall.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd40);

    // Sequential fetch up to PC=12, then a 3-cycle stall and release.
    runNormal(4);
    checkOutput("pc_before_stall", endereco, 32'd12);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    runNormal(3);

    // Branch from PC=76 to 80.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd72);
    runNormal(1);
    checkOutput("pc_before_branch", endereco, 32'd76);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd80);
    runNormal(2);

    // End of memory, stall ignored in FIM, then redirect back to word 5.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd120);
    runNormal(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("fim_addr_held", endereco, 32'd128);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd20);
    runNormal(2);

    // Misaligned redirect with stall, sticky error, then reset from PARADO.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd82);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    runNormal(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect from INICIO straight past the end of memory.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd200);
    runNormal(2);

    // Random traffic over fresh memory contents.
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 25),
                    ($urandom_range(0, 99) < 8),
                    32'($urandom_range(0, 150)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
